// File: rtl/rf_wb_arb_pkg.sv
// Shared constants and types for the register file writeback arbiter.
// ADDR_W/DATA_W are shared with the register file itself.
package rf_wb_arb_pkg;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned ALU_IDX  = 0;
    localparam int unsigned LSU_IDX  = 1;
    localparam int unsigned MDU_IDX  = 2;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [PTR_W-1:0]  rr_ptr_t;

    // Round-robin successor: the source after the one just served.
    function automatic rr_ptr_t ptr_inc(input rr_ptr_t p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/rf_wb_arb_if.sv
// Writeback request, issue/flush and register file write bundle.
// master = execute/decode side, slave = the arbiter.
interface rf_wb_arb_if #(
    parameter int unsigned NUM_REQ = rf_wb_arb_pkg::NUM_REQ,
    parameter int unsigned ADDR_W  = rf_wb_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W  = rf_wb_arb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      iss_vld;
    logic [ADDR_W-1:0]         iss_addr;
    logic                      flush;
    logic                      rf_wb_vld;
    logic [ADDR_W-1:0]         rf_wb_addr;
    logic [DATA_W-1:0]         rf_wb_data;
    logic [31:0]               sb_busy;

    modport master (
        output req_vld, req_addr, req_data, iss_vld, iss_addr, flush,
        input  req_rdy, rf_wb_vld, rf_wb_addr, rf_wb_data, sb_busy
    );

    modport slave (
        input  req_vld, req_addr, req_data, iss_vld, iss_addr, flush,
        output req_rdy, rf_wb_vld, rf_wb_addr, rf_wb_data, sb_busy
    );
endinterface

// File: rtl/rf_wb_arb_dffre.sv
// Reset-enable flop: async active-high reset to ResetVal, load d when en.
module rf_wb_arb_dffre #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= ResetVal;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/rf_wb_arb_rr_arb.sv
// Parameterised round-robin arbiter: one-hot grant to the first requester
// found searching upward (with wrap) from ptr.
module rf_wb_arb_rr_arb #(
    parameter int unsigned N = 3,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    gnt
);
    int          idx;
    logic [PtrW-1:0] sel;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(N)) idx = idx - int'(N);
            sel = PtrW'(idx);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arb.sv
// Writeback arbiter for the single register file write port, plus the
// per-register busy scoreboard that decode uses for RAW stalls.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    rf_wb_arb_if.slave bus
);
    rr_ptr_t              rr_ptr;
    rr_ptr_t              win_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic                 xfer;
    reg_addr_t            win_addr;
    reg_data_t            win_data;
    logic                 wb_vld_d;
    logic [NUM_REGS-1:0]  sb_d;
    logic [NUM_REGS-1:0]  sb_q;

    rf_wb_arb_rr_arb #(.N(NUM_REQ)) u_rr_arb (
        .req (bus.req_vld),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign bus.req_rdy = gnt;
    assign xfer        = |gnt;

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (gnt[k]) begin
                win_idx  = PTR_W'(k);
                win_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
                win_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    rf_wb_arb_dffre #(.Width(PTR_W)) u_ptr (
        .clk (clk),
        .rst (rst),
        .en  (xfer),
        .d   (ptr_inc(win_idx)),
        .q   (rr_ptr)
    );

    // x0 writes are consumed and advance fairness, but never reach the file.
    assign wb_vld_d = xfer && (win_addr != '0);

    rf_wb_arb_dffre #(.Width(1)) u_wb_vld (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (wb_vld_d),
        .q   (bus.rf_wb_vld)
    );

    rf_wb_arb_dffre #(.Width(ADDR_W)) u_wb_addr (
        .clk (clk),
        .rst (rst),
        .en  (xfer),
        .d   (win_addr),
        .q   (bus.rf_wb_addr)
    );

    rf_wb_arb_dffre #(.Width(DATA_W)) u_wb_data (
        .clk (clk),
        .rst (rst),
        .en  (xfer),
        .d   (win_data),
        .q   (bus.rf_wb_data)
    );

    // Set is applied after clear so a same-cycle re-issue keeps the bit busy.
    always_comb begin
        sb_d = sb_q;
        if (bus.flush) begin
            sb_d = '0;
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (bus.rf_wb_vld && (bus.rf_wb_addr == ADDR_W'(i))) sb_d[i] = 1'b0;
                if (bus.iss_vld && (bus.iss_addr == ADDR_W'(i)))     sb_d[i] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;
    end

    rf_wb_arb_dffre #(.Width(NUM_REGS)) u_sb (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (sb_d),
        .q   (sb_q)
    );

    assign bus.sb_busy = sb_q;
endmodule

// File: tb/tb_rf_wb_arb.sv
// Scoreboard bench for rf_wb_arb: expected writebacks are queued as requests
// are driven and popped when the registered output stage should show them.
module tb_rf_wb_arb;
    import rf_wb_arb_pkg::*;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arb_if bus_if ();

    rf_wb_arb u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    wb_t         exp_q[$];
    wb_t         m_cur;
    wb_t         m_hold;
    logic [1:0]  m_ptr;
    logic [31:0] m_sb;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("rf_wb_vld", 32'(bus_if.rf_wb_vld), 32'(m_cur.vld));
        check_eq("rf_wb_addr", 32'(bus_if.rf_wb_addr), 32'(m_cur.addr));
        check_eq("rf_wb_data", bus_if.rf_wb_data, m_cur.data);
        check_eq("sb_busy", bus_if.sb_busy, m_sb);
        check_eq("rr_ptr", 32'(u_dut.rr_ptr), 32'(m_ptr));
    endtask

    task automatic model_reset();
        m_ptr  = '0;
        m_sb   = '0;
        m_cur  = '0;
        m_hold = '0;
        exp_q.delete();
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic apply(input logic [2:0] v, input logic [3*ADDR_W-1:0] addrs,
                         input logic [3*DATA_W-1:0] datas, input logic iv,
                         input logic [ADDR_W-1:0] ia, input logic fl);
        logic [2:0]  g;
        logic [31:0] sb_nxt;
        wb_t         nxt;
        bus_if.req_vld  = v;
        bus_if.req_addr = addrs;
        bus_if.req_data = datas;
        bus_if.iss_vld  = iv;
        bus_if.iss_addr = ia;
        bus_if.flush    = fl;
        #1;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            int idx = (int'(m_ptr) + i) % 3;
            if (g == 3'b000 && v[idx]) g[idx] = 1'b1;
        end
        check_eq("req_rdy", 32'(bus_if.req_rdy), 32'(g));

        nxt      = m_hold;
        nxt.vld  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (g[k]) begin
                nxt.addr = addrs[k*ADDR_W +: ADDR_W];
                nxt.data = datas[k*DATA_W +: DATA_W];
                nxt.vld  = (nxt.addr != '0);
                m_ptr    = 2'((k + 1) % 3);
            end
        end
        m_hold = nxt;
        exp_q.push_back(nxt);

        sb_nxt = m_sb;
        if (fl) begin
            sb_nxt = '0;
        end else begin
            if (m_cur.vld) sb_nxt[m_cur.addr] = 1'b0;
            if (iv) sb_nxt[ia] = 1'b1;
        end
        sb_nxt[0] = 1'b0;

        @(negedge clk);
        m_cur = exp_q.pop_front();
        m_sb  = sb_nxt;
        check_outputs();
    endtask

    task automatic idle();
        apply(3'b000, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        apply(3'b000, '0, '0, 1'b1, a, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus_if.req_vld  = '0;
        bus_if.req_addr = '0;
        bus_if.req_data = '0;
        bus_if.iss_vld  = 1'b0;
        bus_if.iss_addr = '0;
        bus_if.flush    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("req_rdy_rst", 32'(bus_if.req_rdy), 32'h0);
        rst = 1'b0;
        idle();

        // Single ALU request, then x0 from LSU, then MDU alone.
        apply(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, '0, 1'b0);
        apply(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h5555AAAA, 32'h0}, 1'b0, '0, 1'b0);
        apply(3'b100, {5'd6, 5'd0, 5'd0}, {32'h66666666, 32'h0, 32'h0}, 1'b0, '0, 1'b0);
        idle();

        // Fairness: all three held valid for six cycles.
        repeat (6) begin
            apply(3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001},
                  1'b0, '0, 1'b0);
        end
        idle();

        // Scoreboard: set, set-vs-clear collision, then a plain clear.
        issue(5'd7);
        apply(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77777777}, 1'b0, '0, 1'b0);
        issue(5'd7);
        apply(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h70707070, 32'h0}, 1'b0, '0, 1'b0);
        idle();
        idle();

        // Flush with a same-cycle issue and a granted MDU write to reg 9.
        issue(5'd3);
        issue(5'd9);
        issue(5'd31);
        issue(5'd0);
        apply(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99999999, 32'h0, 32'h0}, 1'b1, 5'd4, 1'b1);
        idle();

        // Randomised traffic with issues and occasional flushes.
        for (int n = 0; n < 40; n++) begin
            apply(3'($urandom_range(0, 7)),
                  {5'($urandom), 5'($urandom), 5'($urandom)},
                  {32'($urandom), 32'($urandom), 32'($urandom)},
                  1'($urandom), 5'($urandom), ($urandom_range(0, 9) == 0));
        end
        idle();

        // Async reset between edges while a write is on the output stage.
        issue(5'd12);
        apply(3'b111, {5'd13, 5'd12, 5'd11}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, 1'b0);
        apply(3'b111, {5'd13, 5'd12, 5'd11}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("req_rdy_in_rst", 32'(bus_if.req_rdy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        apply(3'b110, {5'd13, 5'd12, 5'd11}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, 1'b0);
        apply(3'b111, {5'd13, 5'd12, 5'd11}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, 1'b0);
        apply(3'b111, {5'd13, 5'd12, 5'd11}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, 1'b0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Writeback arbiter and scoreboard for the single-write-port integer register file. It shares the register file write port between NUM_REQ writeback sources (ALU, LSU, MDU) using round-robin valid/ready arbitration and a registered output stage. It also tracks a per-register busy scoreboard that the decode unit reads for RAW hazard stalls. It sits between the execute/memory units and the register file.

## Interface
- NUM_REQ, 3: number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = MDU.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_vld  in  NUM_REQ  per-source writeback request.
- req_addr  in  NUM_REQ*ADDR_W  per-source destination register; source k occupies bits [k*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  per-source writeback data, packed the same way.
- req_rdy  out  NUM_REQ  grant; the transfer happens when req_vld[k] & req_rdy[k].
- iss_vld  in  1  decode issued an instruction with a destination register.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- flush  in  1  pipeline flush; clears the scoreboard.
- rf_wb_vld  out  1  register file write enable.
- rf_wb_addr  out  ADDR_W  register file write address.
- rf_wb_data  out  DATA_W  register file write data.
- sb_busy  out  32  scoreboard; bit i = register i has a pending write.

## Operation
- Arbitration:
  - Combinational round-robin over req_vld, starting the search at pointer rr_ptr.
  - At most one req_rdy bit is high per cycle, and only for a valid source.
  - req_rdy is never high for a source whose req_vld is low.
- Pointer update: on a transfer from source k, rr_ptr becomes (k+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Output stage:
  - The winner's addr/data are registered into rf_wb_addr/rf_wb_data.
  - rf_wb_vld is set high the cycle after the transfer.
  - With no transfer, rf_wb_vld is 0 and addr/data hold their previous values.
- x0 writes:
  - A request with addr 0 is still granted, and the pointer still advances.
  - rf_wb_vld is forced to 0 for that transfer.
- Scoreboard, per bit i in 1..31:
  - Set when iss_vld & iss_addr==i.
  - Cleared when rf_wb_vld & rf_wb_addr==i.
  - Simultaneous set and clear of the same bit: set wins.
  - Issue with iss_addr 0 has no effect.
  - sb_busy[0] is constant 0.
- Flush:
  - Clears all sb_busy bits in the next cycle and takes priority over a same-cycle iss_vld.
  - Does not affect rr_ptr, the output stage, or a same-cycle transfer; that write still reaches the register file.
- Back-pressure: the register file always accepts, so the output stage never stalls. Sustained throughput is one write per cycle.

## Timing
- Reset values: rf_wb_vld=0, rf_wb_addr=0, rf_wb_data=0, sb_busy=0, rr_ptr=0. req_rdy is combinational from req_vld and rr_ptr.
- Latency: a transfer in cycle N gives rf_wb_vld=1 in cycle N+1. The register file holds the value from edge N+2, so it is visible to decode reads in cycle N+2.
- Scoreboard timing:
  - An issue in cycle N shows busy in cycle N+1.
  - A writeback with rf_wb_vld in cycle M clears busy in cycle M+1.
- Reset mid-operation: all state returns to reset values immediately (async). Any in-flight output-stage write is lost, and req_rdy reverts to the source-0 search order.
- Requesters must hold req_vld, req_addr and req_data stable until granted. The arbiter does not check this.

## Structure
- Shared package entries:
  - NUM_REQ default and the requester index constants (ALU_IDX=0, LSU_IDX=1, MDU_IDX=2).
  - ADDR_W and DATA_W, shared with the register file.
- One natural sub-module: rr_arb, a parameterised round-robin arbiter taking req and ptr and returning a one-hot gnt. It is reusable by other shared resources.
- Output stage, pointer and scoreboard are built from the codebase's reset-enable flop (DFFRE-style) instances. Reset polarity is adapted to active-high at this block's boundary.

## Test plan
- Single request: ALU req addr 5, data 0xDEADBEEF in cycle 0 → req_rdy=001 in cycle 0; rf_wb_vld=1, addr 5, data 0xDEADBEEF in cycle 1; rr_ptr=1.
- Fairness: all three sources hold req_vld for 6 cycles → grants in order 0,1,2,0,1,2, with one rf_wb_vld each cycle from cycle 1 to cycle 6.
- x0 suppression: LSU req addr 0 → req_rdy[1]=1, rf_wb_vld stays 0, rr_ptr advances to 2.
- Scoreboard set/clear collision: iss addr 7 in cycle 0 → sb_busy[7]=1 in cycle 1. Then in the same cycle, writeback of reg 7 (rf_wb_vld=1) and re-issue of 7 → sb_busy[7] stays 1.
- Flush: busy bits {3,9,31} set; flush together with iss_vld addr 4 → sb_busy=0 next cycle. A same-cycle granted MDU write to reg 9 still appears on rf_wb_vld.
- Async reset mid-burst: assert rst between edges while rf_wb_vld=1 → all outputs 0 immediately. After release, the first grant goes to the lowest-index valid source.
